// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the N-way write-back cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_e;

  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned s_offset,
                                           input int unsigned s_index);
    return addr >> (s_offset + s_index);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned s_offset,
                                             input int unsigned s_index);
    logic [31:0] mask_v;
    mask_v = (32'd1 << s_index) - 32'd1;
    return (addr >> s_offset) & mask_v;
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] tag,
                                            input logic [31:0] index,
                                            input int unsigned s_offset,
                                            input int unsigned s_index);
    return ((tag << s_index) | index) << s_offset;
  endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Combinational tree-PLRU: walks one set's bit vector to a victim and
// produces the vector updated for an access to touch_way.
module plru_tree #(
  parameter  int num_ways = 4,
  localparam int s_way    = $clog2(num_ways)
) (
  input  logic [num_ways-2:0] bits,
  input  logic [s_way-1:0]    touch_way,
  output logic [s_way-1:0]    victim,
  output logic [num_ways-2:0] bits_next
);

  logic [s_way-1:0] vic_node_s;
  logic [s_way-1:0] tch_node_s;

  // Follow the bits from the root; a 0 sends the victim into the lower half.
  always_comb begin
    victim     = '0;
    vic_node_s = '0;
    for (int lvl = 0; lvl < s_way; lvl++) begin
      victim[s_way-1-lvl] = bits[vic_node_s];
      vic_node_s = s_way'(32'd2 * 32'(vic_node_s) + 32'd1 + 32'(bits[vic_node_s]));
    end
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin
    bits_next  = bits;
    tch_node_s = '0;
    for (int lvl = 0; lvl < s_way; lvl++) begin
      bits_next[tch_node_s] = ~touch_way[s_way-1-lvl];
      tch_node_s = s_way'(32'd2 * 32'(tch_node_s) + 32'd1 + 32'(touch_way[s_way-1-lvl]));
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with tree-PLRU
// replacement, between a 256-bit CPU line port and physical memory.
module cache_nway
  import cache_pkg::*;
#(
  parameter  int s_offset = 5,
  parameter  int s_index  = 4,
  parameter  int num_ways = 4,
  localparam int s_tag    = 32 - s_offset - s_index,
  localparam int s_mask   = 2 ** s_offset,
  localparam int s_line   = 8 * s_mask
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata,
  input  logic [s_mask-1:0] mem_byte_enable,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              hit,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int num_sets = 2 ** s_index;
  localparam int s_way    = $clog2(num_ways);

  logic [s_tag-1:0]    tag_r   [num_sets][num_ways];
  logic [s_line-1:0]   data_r  [num_sets][num_ways];
  logic [num_ways-1:0] valid_r [num_sets];
  logic [num_ways-1:0] dirty_r [num_sets];
  logic [num_ways-2:0] plru_r  [num_sets];

  state_e            state_r, state_next_s;
  logic [31:0]       addr_r;
  logic [s_line-1:0] wdata_r;
  logic [s_mask-1:0] be_r;
  logic              is_write_r;
  logic              filled_r;
  logic [s_way-1:0]  victim_r;

  logic [s_tag-1:0]    req_tag_s;
  logic [s_index-1:0]  req_index_s;
  logic                hit_any_s;
  logic [s_way-1:0]    hit_way_s;
  logic [s_way-1:0]    inv_way_s;
  logic [s_way-1:0]    plru_victim_s;
  logic [s_way-1:0]    victim_sel_s;
  logic [num_ways-2:0] plru_next_s;
  logic [s_line-1:0]   hit_line_s;
  logic [s_line-1:0]   merged_s;

  assign req_tag_s   = s_tag'(addr_tag(addr_r, s_offset, s_index));
  assign req_index_s = s_index'(addr_index(addr_r, s_offset, s_index));

  // Tag lookup and lowest-numbered invalid way within the requested set.
  always_comb begin
    hit_any_s = 1'b0;
    hit_way_s = '0;
    inv_way_s = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (valid_r[req_index_s][w] && (tag_r[req_index_s][w] == req_tag_s)) begin
        hit_any_s = 1'b1;
        hit_way_s = s_way'(w);
      end else begin
        hit_any_s = hit_any_s;
      end
      inv_way_s = valid_r[req_index_s][w] ? inv_way_s : s_way'(w);
    end
  end

  plru_tree #(.num_ways(num_ways)) u_plru (
    .bits      (plru_r[req_index_s]),
    .touch_way (hit_way_s),
    .victim    (plru_victim_s),
    .bits_next (plru_next_s)
  );

  assign victim_sel_s = (&valid_r[req_index_s]) ? plru_victim_s : inv_way_s;
  assign hit_line_s   = data_r[req_index_s][hit_way_s];

  // Byte-enable merge of the held write data into the hit line.
  always_comb begin
    merged_s = hit_line_s;
    for (int b = 0; b < s_mask; b++) begin
      merged_s[8*b +: 8] = be_r[b] ? wdata_r[8*b +: 8] : hit_line_s[8*b +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:      state_next_s = (mem_read || mem_write) ? COMPARE : IDLE;
      COMPARE: begin
        if (hit_any_s) begin
          state_next_s = IDLE;
        end else if (valid_r[req_index_s][victim_sel_s] && dirty_r[req_index_s][victim_sel_s]) begin
          state_next_s = WRITEBACK;
        end else begin
          state_next_s = ALLOCATE;
        end
      end
      WRITEBACK: state_next_s = pmem_resp ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_next_s = pmem_resp ? COMPARE : ALLOCATE;
      default:   state_next_s = IDLE;
    endcase
  end

  // Outputs decoded from the current state; everything idles at zero.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    hit          = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 32'd0;
    pmem_wdata   = '0;
    case (state_r)
      COMPARE: begin
        if (hit_any_s) begin
          mem_resp  = 1'b1;
          mem_rdata = hit_line_s;
          hit       = ~filled_r;
        end else begin
          mem_resp  = 1'b0;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(32'(tag_r[req_index_s][victim_r]), 32'(req_index_s),
                                 s_offset, s_index);
        pmem_wdata   = data_r[req_index_s][victim_r];
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = line_addr(32'(req_tag_s), 32'(req_index_s), s_offset, s_index);
      end
      default: mem_resp = 1'b0;
    endcase
  end

  // Request capture in IDLE and the victim choice frozen at the miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= 32'd0;
      wdata_r    <= '0;
      be_r       <= '0;
      is_write_r <= 1'b0;
      filled_r   <= 1'b0;
      victim_r   <= '0;
    end else begin
      if (state_r == IDLE && (mem_read || mem_write)) begin
        addr_r     <= mem_address;
        wdata_r    <= mem_wdata;
        be_r       <= mem_byte_enable;
        is_write_r <= mem_write;
        filled_r   <= 1'b0;
      end
      if (state_r == COMPARE && !hit_any_s) begin
        victim_r <= victim_sel_s;
      end
      if (state_r == ALLOCATE && pmem_resp) begin
        filled_r <= 1'b1;
      end
    end
  end

  // Valid, dirty and PLRU bits; the only cache state that is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else if (state_r == COMPARE && hit_any_s) begin
      plru_r[req_index_s] <= plru_next_s;
      if (is_write_r) begin
        dirty_r[req_index_s][hit_way_s] <= 1'b1;
      end
    end else if (state_r == ALLOCATE && pmem_resp) begin
      valid_r[req_index_s][victim_r] <= 1'b1;
      dirty_r[req_index_s][victim_r] <= 1'b0;
    end
  end

  // Tag and line storage, left unreset.
  always_ff @(posedge clk) begin
    if (!rst && state_r == COMPARE && hit_any_s && is_write_r) begin
      data_r[req_index_s][hit_way_s] <= merged_s;
    end else if (!rst && state_r == ALLOCATE && pmem_resp) begin
      data_r[req_index_s][victim_r] <= pmem_rdata;
      tag_r[req_index_s][victim_r]  <= req_tag_s;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway with a two-cycle memory responder.
module tb_cache_nway;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [31:0]  mem_byte_enable;
  logic [255:0] mem_rdata;
  logic         mem_resp, hit;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [255:0] r_rdata, wb_data, exp_line, wline;
  logic         r_hit, wb_seen, fill_seen;
  logic [31:0]  wb_addr, fill_addr;
  int           r_lat;

  always #5 clk = ~clk;

  cache_nway dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .hit             (hit),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] fill_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = a ^ {8{4'(i)}};
    return l;
  endfunction

  function automatic logic [255:0] wr_line(input int k);
    return {8{32'h3000_0000 + 32'(k)}};
  endfunction

  // One request; memory answers each pmem transfer on its second cycle.
  task automatic access(input logic wr, input logic [31:0] addr,
                        input logic [255:0] wd, input logic [31:0] be);
    int  pend;
    logic done;
    @(posedge clk); #1;
    mem_read = ~wr; mem_write = wr; mem_address = addr;
    mem_wdata = wd; mem_byte_enable = be;
    r_lat = 0; pend = 0; done = 1'b0; r_hit = 1'b0; r_rdata = '0;
    wb_seen = 1'b0; fill_seen = 1'b0; wb_addr = 32'd0; wb_data = '0; fill_addr = 32'd0;
    while (!done && r_lat < 64) begin
      @(posedge clk); #1; r_lat++;
      if (pmem_resp) begin pmem_resp = 1'b0; pend = 0; end
      if (mem_resp) begin
        done = 1'b1; r_hit = hit; r_rdata = mem_rdata;
      end else if (pmem_write) begin
        if (pend == 0) begin wb_seen = 1'b1; wb_addr = pmem_address; wb_data = pmem_wdata; end
        pend++;
        if (pend == 2) pmem_resp = 1'b1;
      end else if (pmem_read) begin
        if (pend == 0) begin fill_seen = 1'b1; fill_addr = pmem_address; end
        pend++;
        if (pend == 2) begin pmem_resp = 1'b1; pmem_rdata = fill_line(pmem_address); end
      end
    end
    check("timeout", done, 1'b1);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = 32'd0;
    mem_wdata = '0; mem_byte_enable = 32'd0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 32'd0);
    check("rst_mem_rdata", mem_rdata, 256'd0);
    rst = 1'b0;

    access(1'b0, 32'h0000_1040, '0, 32'd0);
    check("cold_hit", r_hit, 1'b0);
    check("cold_rdata", r_rdata, fill_line(32'h0000_1040));
    check("cold_fill_addr", fill_addr, 32'h0000_1040);
    check("cold_no_wb", wb_seen, 1'b0);
    check("cold_latency", r_lat, 4);

    access(1'b0, 32'h0000_1040, '0, 32'd0);
    check("rehit_hit", r_hit, 1'b1);
    check("rehit_latency", r_lat, 1);
    check("rehit_no_fill", fill_seen, 1'b0);
    check("rehit_no_wb", wb_seen, 1'b0);
    check("rehit_rdata", r_rdata, fill_line(32'h0000_1040));

    wline = {8{32'hDEAD_BEEF}};
    access(1'b1, 32'h0000_1040, wline, 32'h0000_000F);
    check("wr_hit", r_hit, 1'b1);
    check("wr_premerge", r_rdata, fill_line(32'h0000_1040));
    exp_line = fill_line(32'h0000_1040);
    exp_line[31:0] = 32'hDEAD_BEEF;
    access(1'b0, 32'h0000_1040, '0, 32'd0);
    check("wr_readback", r_rdata, exp_line);

    for (int k = 1; k < 4; k++) begin
      access(1'b0, 32'h0000_1040 + 32'(k) * 32'h200, '0, 32'd0);
      check("set2_fill_addr", fill_addr, 32'h0000_1040 + 32'(k) * 32'h200);
      check("set2_fill_no_wb", wb_seen, 1'b0);
    end
    access(1'b0, 32'h0000_1840, '0, 32'd0);
    check("evict_wb_seen", wb_seen, 1'b1);
    check("evict_wb_addr", wb_addr, 32'h0000_1040);
    check("evict_wb_data", wb_data, exp_line);
    check("evict_fill_addr", fill_addr, 32'h0000_1840);
    check("evict_hit", r_hit, 1'b0);
    check("evict_latency", r_lat, 6);
    check("evict_rdata", r_rdata, fill_line(32'h0000_1840));

    for (int k = 0; k < 4; k++) begin
      access(1'b1, 32'h0000_2060 + 32'(k) * 32'h200, wr_line(k), 32'hFFFF_FFFF);
      check("set3_wr_hit", r_hit, 1'b0);
      check("set3_wr_premerge", r_rdata, fill_line(32'h0000_2060 + 32'(k) * 32'h200));
    end
    access(1'b0, 32'h0000_2060, '0, 32'd0);
    check("set3_w0_hit", r_hit, 1'b1);
    check("set3_w0_data", r_rdata, wr_line(0));
    access(1'b0, 32'h0000_2860, '0, 32'd0);
    check("plru_wb_addr", wb_addr, 32'h0000_2460);
    check("plru_wb_data", wb_data, wr_line(2));
    check("plru_fill_addr", fill_addr, 32'h0000_2860);

    @(posedge clk); #1;
    mem_read = 1'b1; mem_address = 32'h0000_3000;
    cyc = 0;
    while (!pmem_read && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("rst_reach_alloc", pmem_read, 1'b1);
    pmem_resp = 1'b1; pmem_rdata = fill_line(32'h0000_3000); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_pmem_read", pmem_read, 1'b0);
    check("midrst_mem_resp", mem_resp, 1'b0);
    check("midrst_pmem_addr", pmem_address, 32'd0);
    rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    check("postrst_mem_resp", mem_resp, 1'b0);
    access(1'b0, 32'h0000_1640, '0, 32'd0);
    check("postrst_invalid_hit", r_hit, 1'b0);
    check("postrst_invalid_fill", fill_seen, 1'b1);
    check("postrst_no_wb", wb_seen, 1'b0);
    access(1'b0, 32'h0000_2060, '0, 32'd0);
    check("postrst_dirty_dropped", wb_seen, 1'b0);
    check("postrst_set3_fill", fill_addr, 32'h0000_2060);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
